// File: rtl/katp91_bus_pkg.sv
// rtl/katp91_bus_pkg.sv - shared widths, RAM window limit and state encoding for the RAM bus controller
package katp91_bus_pkg;

    localparam int RAM_BUS_SIZE = 15;
    localparam int CPU_ADDR_W   = 16;
    localparam int DATA_W       = 8;
    localparam logic [CPU_ADDR_W-1:0] RAM_LIMIT = 16'h7FFF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        ERR
    } bus_state_t;

    function automatic logic in_ram(input logic [CPU_ADDR_W-1:0] addr);
        return addr <= RAM_LIMIT;
    endfunction

endpackage

// File: rtl/ram_bus_controller_if.sv
// rtl/ram_bus_controller_if.sv - CPU load/store handshake and asynchronous RAM pin bundle
interface ram_bus_controller_if;
    import katp91_bus_pkg::*;

    logic                    cpu_req;
    logic                    cpu_ready;
    logic                    cpu_we;
    logic [CPU_ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]       cpu_wdata;
    logic [DATA_W-1:0]       cpu_rdata;
    logic                    cpu_ack;
    logic                    cpu_err;
    logic [RAM_BUS_SIZE-1:0] ram_addr;
    logic [DATA_W-1:0]       ram_wdata;
    logic                    ram_oe;
    logic [DATA_W-1:0]       ram_rdata;
    logic                    ram_r;
    logic                    ram_w;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_ready, cpu_rdata, cpu_ack, cpu_err,
        input  ram_addr, ram_wdata, ram_oe, ram_r, ram_w
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_ready, cpu_rdata, cpu_ack, cpu_err,
        output ram_addr, ram_wdata, ram_oe, ram_r, ram_w
    );

endinterface

// File: rtl/bus_phase_timer.sv
// rtl/bus_phase_timer.sv - reloadable 3-bit down-counter flagging the last cycle of a bus phase
module bus_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] value,
    output logic       last
);

    logic [2:0] count;

    // Count holds the cycles left in the current phase, including this one; it parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 3'd0;
        end else if (load) begin
            count <= value;
        end else if (count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    assign last = (count == 3'd1);

endmodule

// File: rtl/ram_bus_controller.sv
// rtl/ram_bus_controller.sv - sequences setup/strobe/hold on the asynchronous RAM for one CPU access at a time
module ram_bus_controller
    import katp91_bus_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic               clk,
    input  logic               rst,
    ram_bus_controller_if.slave bus
);

    localparam logic [2:0] SETUP_V  = 3'(SETUP_CYCLES);
    localparam logic [2:0] STROBE_V = 3'(STROBE_CYCLES);
    localparam logic [2:0] HOLD_V   = 3'(HOLD_CYCLES);

    bus_state_t state;
    logic       we_q;
    logic       accept;
    logic       tmr_load;
    logic [2:0] tmr_value;
    logic       tmr_last;

    assign accept = bus.cpu_req && bus.cpu_ready;

    // The timer is reloaded on the same edge that enters each timed phase.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = 3'd0;
        case (state)
            IDLE: if (accept && in_ram(bus.cpu_addr)) begin
                tmr_load  = 1'b1;
                tmr_value = SETUP_V;
            end
            SETUP: if (tmr_last) begin
                tmr_load  = 1'b1;
                tmr_value = STROBE_V;
            end
            STROBE: if (tmr_last) begin
                tmr_load  = 1'b1;
                tmr_value = HOLD_V;
            end
            default: ;
        endcase
    end

    bus_phase_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .last  (tmr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            bus.cpu_ready <= 1'b1;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_err   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_oe    <= 1'b0;
            bus.ram_r     <= 1'b0;
            bus.ram_w     <= 1'b0;
        end else begin
            bus.cpu_ack <= 1'b0;
            bus.cpu_err <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    bus.cpu_ready <= 1'b0;
                    if (in_ram(bus.cpu_addr)) begin
                        state         <= SETUP;
                        we_q          <= bus.cpu_we;
                        bus.ram_addr  <= bus.cpu_addr[RAM_BUS_SIZE-1:0];
                        bus.ram_wdata <= bus.cpu_wdata;
                        bus.ram_oe    <= bus.cpu_we;
                    end else begin
                        state       <= ERR;
                        bus.cpu_ack <= 1'b1;
                        bus.cpu_err <= 1'b1;
                    end
                end
                SETUP: if (tmr_last) begin
                    state     <= STROBE;
                    bus.ram_w <= we_q;
                    bus.ram_r <= !we_q;
                end
                STROBE: if (tmr_last) begin
                    state     <= HOLD;
                    bus.ram_w <= 1'b0;
                    bus.ram_r <= 1'b0;
                    if (!we_q) begin
                        bus.cpu_rdata <= bus.ram_rdata;
                    end
                end
                HOLD: if (tmr_last) begin
                    state       <= DONE;
                    bus.cpu_ack <= 1'b1;
                    bus.ram_oe  <= 1'b0;
                end
                DONE, ERR: begin
                    state         <= IDLE;
                    bus.cpu_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_controller.sv
// tb/tb_ram_bus_controller.sv - directed scoreboard bench for ram_bus_controller
module tb_ram_bus_controller;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [15:0] addr  = '0;
    logic [7:0]  wdata = '0;
    bit          sel   = 1'b0;

    logic [7:0] mem0 [0:32767];
    logic [7:0] mem1 [0:32767];

    ram_bus_controller_if b0 ();
    ram_bus_controller_if b1 ();

    assign b0.cpu_req   = req && !sel;
    assign b1.cpu_req   = req && sel;
    assign b0.cpu_we    = we;
    assign b1.cpu_we    = we;
    assign b0.cpu_addr  = addr;
    assign b1.cpu_addr  = addr;
    assign b0.cpu_wdata = wdata;
    assign b1.cpu_wdata = wdata;
    assign b0.ram_rdata = mem0[b0.ram_addr];
    assign b1.ram_rdata = mem1[b1.ram_addr];

    always @(posedge b0.ram_w) mem0[b0.ram_addr] = b0.ram_wdata;
    always @(posedge b1.ram_w) mem1[b1.ram_addr] = b1.ram_wdata;

    ram_bus_controller dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    ram_bus_controller #(
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (3),
        .HOLD_CYCLES   (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    wire        s_ready = sel ? b1.cpu_ready : b0.cpu_ready;
    wire        s_ack   = sel ? b1.cpu_ack   : b0.cpu_ack;
    wire        s_err   = sel ? b1.cpu_err   : b0.cpu_err;
    wire [7:0]  s_rdata = sel ? b1.cpu_rdata : b0.cpu_rdata;
    wire        s_r     = sel ? b1.ram_r     : b0.ram_r;
    wire        s_w     = sel ? b1.ram_w     : b0.ram_w;
    wire        s_oe    = sel ? b1.ram_oe    : b0.ram_oe;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic [7:0] last_rd [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // d is the store data for stores and the value the RAM holds for loads.
    task automatic run_txn(input bit s, input logic w, input logic [15:0] a, input logic [7:0] d,
                           input int exp_lat,
                           output logic [31:0] wt, output logic [31:0] rt, output logic [31:0] ot);
        exp_t e;
        exp_t got;
        int   n;
        logic busy_ready;
        sel = s;
        @(negedge clk);
        check("ready_before_accept", {31'd0, s_ready}, 32'd1);
        req = 1'b1; we = w; addr = a; wdata = d;
        e.err   = a[15];
        e.rdata = (w || a[15]) ? last_rd[s] : d;
        last_rd[s] = e.rdata;
        exp_q.push_back(e);
        wt = '0; rt = '0; ot = '0; busy_ready = 1'b0;
        @(posedge clk);
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) req = 1'b0;
            wt[n] = s_w;
            rt[n] = s_r;
            ot[n] = s_oe;
            busy_ready |= s_ready;
            if (s_w && s_r) busy_ready = 1'b1;
            if (s_ack) break;
        end
        check("latency", n, exp_lat);
        check("ready_low_while_busy", {31'd0, busy_ready}, 32'd0);
        got = exp_q.pop_front();
        if (n <= 20) begin
            check("rdata", {24'd0, s_rdata}, {24'd0, got.rdata});
            check("err", {31'd0, s_err}, {31'd0, got.err});
        end
    endtask

    initial begin
        logic [31:0] wt, rt, ot;
        int   ack_cyc[$];
        int   bad_ready;
        int   acks;
        exp_t got;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'd0, b0.cpu_ready}, 32'd1);
        check("rst_ack", {31'd0, b0.cpu_ack}, 32'd0);
        check("rst_err", {31'd0, b0.cpu_err}, 32'd0);
        check("rst_rdata", {24'd0, b0.cpu_rdata}, 32'd0);
        check("rst_ram_addr", {17'd0, b0.ram_addr}, 32'd0);
        check("rst_ram_wdata", {24'd0, b0.ram_wdata}, 32'd0);
        check("rst_strobes_oe", {29'd0, b0.ram_oe, b0.ram_r, b0.ram_w}, 32'd0);

        run_txn(0, 1'b1, 16'h1234, 8'hA5, 4, wt, rt, ot);
        check("st_w_trace", wt, 32'h4);
        check("st_r_trace", rt, 32'h0);
        check("st_oe_trace", ot, 32'hE);
        check("st_ram_addr", {17'd0, b0.ram_addr}, 32'h1234);
        check("st_mem", {24'd0, mem0[15'h1234]}, 32'hA5);

        run_txn(0, 1'b0, 16'h1234, 8'hA5, 4, wt, rt, ot);
        check("ld_w_trace", wt, 32'h0);
        check("ld_r_trace", rt, 32'h4);
        check("ld_oe_trace", ot, 32'h0);

        run_txn(0, 1'b0, 16'h8000, 8'h00, 1, wt, rt, ot);
        check("err_pins_trace", wt | rt | ot, 32'h0);
        check("err_ram_addr_kept", {17'd0, b0.ram_addr}, 32'h1234);

        run_txn(1, 1'b1, 16'h7FFF, 8'h5A, 7, wt, rt, ot);
        check("slow_st_w_trace", wt, 32'h38);
        check("slow_st_oe_trace", ot, 32'h7E);
        check("slow_st_r_trace", rt, 32'h0);
        check("slow_st_ram_addr", {17'd0, b1.ram_addr}, 32'h7FFF);
        check("slow_st_mem", {24'd0, mem1[15'h7FFF]}, 32'h5A);

        run_txn(1, 1'b0, 16'h7FFF, 8'h5A, 7, wt, rt, ot);
        check("slow_ld_r_trace", rt, 32'h38);

        // Request held high across two stores; inputs scrambled while busy.
        sel = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 8'h11;
        got.rdata = last_rd[0]; got.err = 1'b0;
        exp_q.push_back(got);
        exp_q.push_back(got);
        bad_ready = 0;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin addr = 16'h8001; wdata = 8'hEE; end
            if (n == 4) begin addr = 16'h0011; wdata = 8'h22; end
            if (s_ack) begin
                ack_cyc.push_back(n);
                got = exp_q.pop_front();
                check("b2b_err", {31'd0, s_err}, {31'd0, got.err});
            end
            if (n == 5) check("b2b_idle_gap_ready", {31'd0, s_ready}, 32'd1);
            if (n == 6) begin
                check("b2b_second_addr", {17'd0, b0.ram_addr}, 32'h0011);
                req = 1'b0;
            end
            if (((n >= 1 && n <= 4) || (n >= 6 && n <= 9)) && s_ready) bad_ready++;
        end
        check("b2b_ack_count", ack_cyc.size(), 2);
        if (ack_cyc.size() == 2) begin
            check("b2b_ack1_cycle", ack_cyc[0], 4);
            check("b2b_ack2_cycle", ack_cyc[1], 9);
        end
        check("b2b_ready_busy", bad_ready, 0);
        check("b2b_mem_first", {24'd0, mem0[15'h0010]}, 32'h11);
        check("b2b_mem_second", {24'd0, mem0[15'h0011]}, 32'h22);
        while (exp_q.size() > 0) got = exp_q.pop_front();

        // Reset while a load is strobing.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("mid_rst_strobe_high", {31'd0, b0.ram_r}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ram_r", {31'd0, b0.ram_r}, 32'd0);
        check("mid_rst_ready", {31'd0, b0.cpu_ready}, 32'd1);
        check("mid_rst_rdata", {24'd0, b0.cpu_rdata}, 32'd0);
        check("mid_rst_ram_addr", {17'd0, b0.ram_addr}, 32'd0);
        acks = 0;
        if (b0.cpu_ack) acks++;
        repeat (10) begin
            @(negedge clk);
            if (b0.cpu_ack) acks++;
        end
        check("mid_rst_no_ack", acks, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
